// File: rtl/control_stack.sv
// Fetch/execute sequencer with PC, return-address stack and edge-triggered interrupts.
// Optional macro CONTROL_STACK_OVF_TRAP_EN: a push on a full stack vectors to TRAP_VEC.
module control_stack #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = 0,
    parameter int IRQ_VEC     = 'hFD,
    parameter int TRAP_VEC    = 'hFE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          irq,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    output logic [3:0]    alu_opcode,
    input  logic [DW-1:0] alu_out,
    output logic [1:0]    rf_read1,
    output logic [1:0]    rf_read2,
    input  logic [DW-1:0] rf_out1,
    input  logic [DW-1:0] rf_out2,
    output logic          rf_write,
    output logic [1:0]    rf_writereg,
    output logic [DW-1:0] rf_data,
    output logic [AW-1:0] umem_addr,
    output logic [DW-1:0] umem_wdata,
    output logic          umem_we,
    input  logic [DW-1:0] umem_rdata,
    output logic          irq_ack,
    output logic          stack_ovf,
    output logic          stack_unf
);

    typedef enum logic [1:0] {S_FETCH, S_OPERAND, S_MEMRD} state_t;

    localparam int SPW = $clog2(STACK_DEPTH + 1);
`ifdef CONTROL_STACK_OVF_TRAP_EN
    localparam bit OVF_TRAP = 1'b1;
`else
    localparam bit OVF_TRAP = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0] stack_q [STACK_DEPTH];
    logic [AW-1:0] stack_d [STACK_DEPTH];
    logic          ie_q, ie_d, irq_pend_q, irq_pend_d, irq_prev_q;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    logic [DW-1:0] cur;
    logic [3:0]    op;
    logic [AW-1:0] pc_inc, opr, stack_top, push_val, push_tgt;
    logic          push, stack_full, irq_rise, take_irq;

    always_comb begin
        // Decode comes straight from the ROM in FETCH, from the latched copy afterwards.
        cur        = (state_q == S_FETCH) ? imem_data : instr_q;
        op         = cur[DW-1:DW-4];
        pc_inc     = pc_q + 1'b1;
        opr        = imem_data[AW-1:0];
        stack_full = (sp_q == SPW'(STACK_DEPTH));
        irq_rise   = irq & ~irq_prev_q;
        take_irq   = (state_q == S_FETCH) && irq_pend_q && ie_q;
        stack_top  = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp_q == SPW'(i + 1)) stack_top = stack_q[i];

        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        sp_d       = sp_q;
        stack_d    = stack_q;
        ie_d       = ie_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        irq_pend_d = take_irq ? irq_rise : (irq_pend_q | irq_rise);
        push       = 1'b0;
        push_val   = pc_q;
        push_tgt   = pc_q;

        alu_opcode  = op;
        rf_read1    = cur[3:2];
        rf_read2    = cur[1:0];
        rf_write    = 1'b0;
        rf_writereg = cur[1:0];
        rf_data     = alu_out;
        umem_addr   = (state_q == S_MEMRD) ? addr_q : opr;
        umem_wdata  = rf_out1;
        umem_we     = 1'b0;
        irq_ack     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (take_irq) begin
                    irq_ack  = 1'b1;
                    ie_d     = 1'b0;
                    push     = 1'b1;
                    push_val = pc_q;
                    push_tgt = AW'(IRQ_VEC);
                end else if (!op[3]) begin
                    rf_write = 1'b1;
                    pc_d     = pc_inc;
                end else if (op == 4'h9 && cur[3:0] == 4'hF) begin
                    pc_d = pc_inc;
                end else if (op == 4'hB) begin
                    if (sp_q == '0) begin
                        unf_d = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        pc_d = stack_top;
                        sp_d = sp_q - 1'b1;
                        if (cur[0]) ie_d = 1'b1;
                    end
                end else begin
                    instr_d = imem_data;
                    pc_d    = pc_inc;
                    state_d = S_OPERAND;
                end
            end
            S_OPERAND: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    4'h8: begin
                        rf_write = 1'b1;
                        rf_data  = imem_data;
                    end
                    4'h9: pc_d = opr;
                    4'hA: begin
                        push     = 1'b1;
                        push_val = pc_inc;
                        push_tgt = opr;
                    end
                    4'hC: if (rf_out1 == rf_out2) pc_d = opr;
                    4'hD: if (rf_out1 != rf_out2) pc_d = opr;
                    4'hE: umem_we = 1'b1;
                    4'hF: begin
                        addr_d  = opr;
                        state_d = S_MEMRD;
                    end
                    default: ;
                endcase
            end
            S_MEMRD: begin
                rf_write = 1'b1;
                rf_data  = umem_rdata;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (push) begin
            if (stack_full) begin
                ovf_d = 1'b1;
                pc_d  = OVF_TRAP ? AW'(TRAP_VEC) : push_tgt;
                if (OVF_TRAP) ie_d = 1'b0;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++)
                    if (sp_q == SPW'(i)) stack_d[i] = push_val;
                sp_d = sp_q + 1'b1;
                pc_d = push_tgt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= AW'(RESET_VEC);
            addr_q     <= '0;
            instr_q    <= '0;
            sp_q       <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
            ie_q       <= 1'b1;
            irq_pend_q <= 1'b0;
            irq_prev_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            sp_q       <= sp_d;
            stack_q    <= stack_d;
            ie_q       <= ie_d;
            irq_pend_q <= irq_pend_d;
            irq_prev_q <= irq;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign imem_addr = pc_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: tb/tb_control_stack.sv
// Directed, table-driven bench for control_stack (DW=AW=8, STACK_DEPTH=4).
module tb_control_stack;

    logic       clk = 1'b0;
    logic       reset, irq;
    logic [7:0] imem_addr, imem_data, alu_out, rf_out1, rf_out2, rf_data;
    logic [7:0] umem_addr, umem_wdata, umem_rdata;
    logic [3:0] alu_opcode;
    logic [1:0] rf_read1, rf_read2, rf_writereg;
    logic       rf_write, umem_we, irq_ack, stack_ovf, stack_unf;
    logic [7:0] rom [256];

    int n_pass = 0;
    int n_total = 0;

    control_stack #(.DW(8), .AW(8), .STACK_DEPTH(4), .RESET_VEC(0),
                    .IRQ_VEC('hFD), .TRAP_VEC('hFE)) dut (
        .clk(clk), .reset(reset), .irq(irq),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .alu_opcode(alu_opcode), .alu_out(alu_out),
        .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_out1(rf_out1), .rf_out2(rf_out2),
        .rf_write(rf_write), .rf_writereg(rf_writereg), .rf_data(rf_data),
        .umem_addr(umem_addr), .umem_wdata(umem_wdata), .umem_we(umem_we),
        .umem_rdata(umem_rdata), .irq_ack(irq_ack),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;
    always_comb imem_data = rom[imem_addr];

    typedef struct {
        logic [7:0] instr, opr, r1, r2;
        int         cyc;
        logic [7:0] pc;
        logic       wr;
        logic [1:0] wreg;
        logic [7:0] wdata;
        logic       we;
        logic [7:0] uaddr, uwdata;
        logic       unf;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 8'h9F;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic       seen_wr, seen_we;
        logic [1:0] got_wreg;
        logic [7:0] got_wdata, got_uaddr, got_uwdata, exp_pc5;
        logic [7:0] ret_pc [4];

        reset = 1'b1; irq = 1'b0;
        alu_out = 8'hC3; umem_rdata = 8'h6E; rf_out1 = 8'h00; rf_out2 = 8'h00;
        rom_clear();
        #1;
        chk("reset imem_addr", imem_addr, 8'h00);
        chk("reset rf_write", rf_write, 0);
        chk("reset umem_we", umem_we, 0);
        chk("reset irq_ack", irq_ack, 0);
        chk("reset stack_ovf", stack_ovf, 0);
        chk("reset stack_unf", stack_unf, 0);

        //        instr  opr    r1     r2    cyc pc     wr wreg wdata  we uaddr  uwdata unf
        vecs[0]  = '{8'h15, 8'h00, 8'h00, 8'h00, 1, 8'h01, 1, 1, 8'hC3, 0, 8'h00, 8'h00, 0};
        vecs[1]  = '{8'h7E, 8'h00, 8'h00, 8'h00, 1, 8'h01, 1, 2, 8'hC3, 0, 8'h00, 8'h00, 0};
        vecs[2]  = '{8'h30, 8'h00, 8'h00, 8'h00, 1, 8'h01, 1, 0, 8'hC3, 0, 8'h00, 8'h00, 0};
        vecs[3]  = '{8'h9F, 8'h00, 8'h00, 8'h00, 1, 8'h01, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[4]  = '{8'h81, 8'h5A, 8'h00, 8'h00, 2, 8'h02, 1, 1, 8'h5A, 0, 8'h00, 8'h00, 0};
        vecs[5]  = '{8'h90, 8'h40, 8'h00, 8'h00, 2, 8'h40, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[6]  = '{8'hC0, 8'h80, 8'h33, 8'h33, 2, 8'h80, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[7]  = '{8'hC0, 8'h80, 8'h33, 8'h34, 2, 8'h02, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[8]  = '{8'hD0, 8'h80, 8'h33, 8'h33, 2, 8'h02, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[9]  = '{8'hD0, 8'h80, 8'h33, 8'h34, 2, 8'h80, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[10] = '{8'hE4, 8'h07, 8'h33, 8'h34, 2, 8'h02, 0, 0, 8'h00, 1, 8'h07, 8'h33, 0};
        vecs[11] = '{8'hF2, 8'h07, 8'h00, 8'h00, 3, 8'h02, 1, 2, 8'h6E, 0, 8'h00, 8'h00, 0};
        vecs[12] = '{8'hB0, 8'h00, 8'h00, 8'h00, 1, 8'h01, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1};
        vecs[13] = '{8'hA0, 8'h40, 8'h00, 8'h00, 2, 8'h40, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0};

        for (int v = 0; v < 14; v++) begin
            rom_clear();
            rom[0] = vecs[v].instr;
            rom[1] = vecs[v].opr;
            rf_out1 = vecs[v].r1;
            rf_out2 = vecs[v].r2;
            do_reset();
            seen_wr = 0; seen_we = 0;
            got_wreg = 0; got_wdata = 0; got_uaddr = 0; got_uwdata = 0;
            for (int c = 0; c < vecs[v].cyc; c++) begin
                if (rf_write) begin
                    seen_wr = 1; got_wreg = rf_writereg; got_wdata = rf_data;
                end
                if (umem_we) begin
                    seen_we = 1; got_uaddr = umem_addr; got_uwdata = umem_wdata;
                end
                tick();
            end
            chk($sformatf("v%0d pc", v), imem_addr, vecs[v].pc);
            chk($sformatf("v%0d rf_write", v), seen_wr, vecs[v].wr);
            if (vecs[v].wr) begin
                chk($sformatf("v%0d rf_writereg", v), got_wreg, vecs[v].wreg);
                chk($sformatf("v%0d rf_data", v), got_wdata, vecs[v].wdata);
            end
            chk($sformatf("v%0d umem_we", v), seen_we, vecs[v].we);
            if (vecs[v].we) begin
                chk($sformatf("v%0d umem_addr", v), got_uaddr, vecs[v].uaddr);
                chk($sformatf("v%0d umem_wdata", v), got_uwdata, vecs[v].uwdata);
            end
            chk($sformatf("v%0d stack_unf", v), stack_unf, vecs[v].unf);
        end

        // LD then ALU back to back, cycle by cycle
        rom_clear();
        rom[0] = 8'h81; rom[1] = 8'h5A; rom[2] = 8'h15;
        do_reset();
        chk("seq ld c1 rf_write", rf_write, 0);
        tick();
        chk("seq ld c2 rf_write", rf_write, 1);
        chk("seq ld c2 rf_data", rf_data, 8'h5A);
        tick();
        chk("seq alu c3 rf_write", rf_write, 1);
        chk("seq alu c3 rf_data", rf_data, 8'hC3);
        tick();
        chk("seq c4 imem_addr", imem_addr, 8'h03);

        // Async reset in the middle of LDU
        rom_clear();
        rom[0] = 8'hF2; rom[1] = 8'h07;
        do_reset();
        tick(); tick();
        chk("ldu memrd rf_write", rf_write, 1);
        chk("ldu memrd umem_addr", umem_addr, 8'h07);
        #2 reset = 1'b1;
        #1;
        chk("mid-reset imem_addr", imem_addr, 8'h00);
        chk("mid-reset rf_write", rf_write, 0);
        chk("mid-reset umem_we", umem_we, 0);
        @(posedge clk); #1 reset = 1'b0;
        chk("post-reset opcode", alu_opcode, 4'hF);
        tick();
        chk("post-reset pc", imem_addr, 8'h01);

        // PC wraps from 0xFF to 0x00
        rom_clear();
        rom[0] = 8'h90; rom[1] = 8'hFF;
        do_reset();
        tick(); tick();
        chk("wrap jmp pc", imem_addr, 8'hFF);
        tick();
        chk("wrap pc", imem_addr, 8'h00);

        // CALL/RTS round trip, then a second RTS proves sp is back at 0
        rom_clear();
        rom[0] = 8'h90; rom[1] = 8'h10;
        rom[8'h10] = 8'hA0; rom[8'h11] = 8'h40;
        rom[8'h40] = 8'hB0; rom[8'h12] = 8'hB0;
        do_reset();
        tick(); tick();
        tick(); tick();
        chk("call pc", imem_addr, 8'h40);
        tick();
        chk("rts pc", imem_addr, 8'h12);
        chk("rts stack_unf", stack_unf, 0);
        tick();
        chk("extra rts stack_unf", stack_unf, 1);
        chk("extra rts pc", imem_addr, 8'h13);

        // Five nested CALLs then five RTS
        rom_clear();
        for (int k = 0; k < 5; k++) begin
            rom[8'(k * 16)]     = 8'hA0;
            rom[8'(k * 16 + 1)] = 8'(k * 16 + 16);
        end
        rom[8'h50] = 8'hB0; rom[8'hFE] = 8'hB0;
        rom[8'h32] = 8'hB0; rom[8'h22] = 8'hB0; rom[8'h12] = 8'hB0; rom[8'h02] = 8'hB0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(); tick();
            chk($sformatf("nest call%0d pc", k + 1), imem_addr, (k + 1) * 16);
            chk($sformatf("nest call%0d stack_ovf", k + 1), stack_ovf, 0);
        end
`ifdef CONTROL_STACK_OVF_TRAP_EN
        exp_pc5 = 8'hFE;
`else
        exp_pc5 = 8'h50;
`endif
        tick(); tick();
        chk("nest call5 stack_ovf", stack_ovf, 1);
        chk("nest call5 pc", imem_addr, exp_pc5);
        ret_pc[0] = 8'h32; ret_pc[1] = 8'h22; ret_pc[2] = 8'h12; ret_pc[3] = 8'h02;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("nest rts%0d pc", k + 1), imem_addr, ret_pc[k]);
            chk($sformatf("nest rts%0d stack_unf", k + 1), stack_unf, 0);
        end
        tick();
        chk("nest rts5 stack_unf", stack_unf, 1);
        chk("nest rts5 pc", imem_addr, 8'h03);

        // Interrupt raised during OPERAND, nested request held until RTI
        rom_clear();
        rom[0] = 8'h90; rom[1] = 8'h20;
        rom[8'h20] = 8'h81; rom[8'h21] = 8'h11;
        rom[8'hFD] = 8'h9F; rom[8'hFE] = 8'hB1;
        do_reset();
        tick(); tick();
        tick();
        chk("irq operand pc", imem_addr, 8'h21);
        irq = 1'b1;
        chk("irq operand ack", irq_ack, 0);
        tick();
        chk("irq entry pc", imem_addr, 8'h22);
        chk("irq entry ack", irq_ack, 1);
        chk("irq entry rf_write", rf_write, 0);
        irq = 1'b0;
        tick();
        chk("irq vector pc", imem_addr, 8'hFD);
        chk("irq vector ack", irq_ack, 0);
        irq = 1'b1;
        tick();
        chk("irq masked pc", imem_addr, 8'hFE);
        chk("irq masked ack", irq_ack, 0);
        irq = 1'b0;
        tick();
        chk("rti pc", imem_addr, 8'h22);
        chk("rti pending ack", irq_ack, 1);
        tick();
        chk("second entry pc", imem_addr, 8'hFD);
        chk("second entry ack", irq_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
